cover_event_serializer: RTL and testbench
=========================================

Name: cover_event_serializer

Overview:
- Collects per-point coverage hits from one wide valid vector (one bit per toggle point) and deduplicates them against a seen-bitmap.
- Reports each newly covered point exactly once as a global index through a single valid/ready port, in round-robin order.
- Sits between a coverage probe group and the single-index coverage reporting channel, so the shared reporting resource sees at most one event per cycle.

Parameters:
- WIDTH, 65, number of cover points handled (bit i of valid is point i)
- COVER_INDEX, 0, global index of point 0; emitted index = COVER_INDEX + i
- IDX_W, 64, width of emitted index

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- valid  input  WIDTH  per-point hit strobes, sampled every cycle
- clear  input  1  synchronous clear of coverage history (seen, pending, ptr)
- out_valid  output  1  out_index holds an unreported point
- out_ready  input  1  consumer accepts out_index this cycle
- out_index  output  IDX_W  global cover index being reported
- hit_count  output  $clog2(WIDTH+1)  number of distinct points loaded for report since reset/clear
- all_covered  output  1  every point has been loaded for report (&seen)

Behaviour:
- Reset values: out_valid=0, out_index=0, hit_count=0, all_covered=0; internal pending=0, seen=0, ptr=0. valid is ignored in reset cycles.
- State: pending[WIDTH] holds hits awaiting report, seen[WIDTH] holds points already loaded, ptr is the round-robin start.
- Slot free in cycle t when !out_valid or (out_valid && out_ready).
- Selection:
  - When the slot is free and pending!=0, pick the first set pending bit i, scanning ptr..WIDTH-1 then 0..ptr-1.
  - Selection uses registered pending only; hits arriving this cycle are not eligible.
- Load on clock edge after selection: out_index=COVER_INDEX+i (zero-extended to IDX_W), out_valid=1, seen[i]=1, pending[i]=0, ptr=(i+1==WIDTH)?0:i+1, hit_count+=1.
- Slot free with pending==0: out_valid drops to 0 after a completed handshake; out_index holds its last value.
- Pending update per bit: pending_next[i] = (pending[i] | (valid[i] & ~seen[i])) & ~sel[i]. A valid[i] in the same cycle i is selected is absorbed and never re-reported.
- Latency: valid[i] at cycle t with an empty, idle block gives out_valid=1 and out_index=COVER_INDEX+i at t+2.
- Handshake:
  - While out_valid=1 && out_ready=0, out_index is stable and no load occurs.
  - Back-to-back throughput is one index per cycle while out_ready=1.
- Duplicates: a repeated or sustained valid[i] after seen[i]=1 is ignored until clear.
- clear (and not reset): seen=0, pending=0, ptr=0, hit_count=0 next cycle; valid that cycle is ignored.
  - An index already in the output register stays valid until accepted. It is not recounted.
  - No new load occurs in the clear cycle.
- Reset has priority over clear. Reset mid-handshake drops out_valid the next cycle; the in-flight index is lost.
- hit_count is at most WIDTH, so it never wraps. all_covered is registered and equals &seen.
- Without SYNTHESIS guards the block is fully synthesizable; no DPI calls in this block.

Test Plan:
- Single hit: reset, then valid=1<<5 for 1 cycle, out_ready=1 -> out_valid at +2 cycles, out_index=5 (COVER_INDEX=0) for 1 cycle; hit_count=1; valid bit 5 held high for 20 more cycles -> no further output.
- Round-robin order: valid bits {3,64,0} in one cycle, out_ready=1 -> indices 0,3,64 on 3 consecutive cycles. Then with ptr=0 (after 64) and later hits {2,1} -> 1,2.
- Backpressure: pending point 7, out_ready=0 for 5 cycles -> out_valid=1, out_index=7 stable. Meanwhile hit 9 arrives; on out_ready=1 -> 7 accepted, 9 presented next cycle.
- Index offset: COVER_INDEX=8875, valid bit 64 -> out_index=8939.
- Clear and reset: hits {1,2} pending, out_index=1 waiting with out_ready=0, pulse clear -> 1 still presented and accepted, 2 never reported, hit_count=0; valid bit 1 afterwards is reported again. Reset asserted mid-stream -> next cycle out_valid=0, hit_count=0.
- Full coverage: all 65 bits asserted in one cycle, out_ready=1 -> indices 0..64 in order over 65 cycles, hit_count=65, all_covered=1 after the last load.

Source files
------------

// File: rtl/cover_event_serializer.sv
// Deduplicating coverage-hit serializer: collects per-point hit strobes and
// reports each newly covered point once, round-robin, over a valid/ready port.
module cover_event_serializer #(
    parameter int unsigned     WIDTH       = 65,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int unsigned     IDX_W       = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic [$clog2(WIDTH+1)-1:0]   hit_count,
    output logic                         all_covered
);

    localparam int unsigned     PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned     HC_W  = $clog2(WIDTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(WIDTH - 1);

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] seen;
    logic [PTR_W-1:0] ptr;

    logic             slot_free;
    logic             load;
    logic             found_hi;
    logic             found_lo;
    logic [PTR_W-1:0] sel_hi;
    logic [PTR_W-1:0] sel_lo;
    logic [PTR_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_onehot;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] seen_next;

    assign slot_free = !out_valid || out_ready;
    assign load      = slot_free && (pending != '0) && !clear && !reset;

    // Round-robin pick: first pending bit at/after ptr, else first pending bit overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found_hi && pending[i] && (PTR_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                sel_hi   = PTR_W'(i);
            end
            if (!found_lo && pending[i]) begin
                found_lo = 1'b1;
                sel_lo   = PTR_W'(i);
            end
        end
        sel_idx = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        sel_onehot = '0;
        if (load) begin
            sel_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << sel_idx;
        end
        pending_next = (pending | (valid & ~seen)) & ~sel_onehot;
        seen_next    = seen | sel_onehot;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending     <= '0;
            seen        <= '0;
            ptr         <= '0;
            hit_count   <= '0;
            all_covered <= 1'b0;
            out_valid   <= 1'b0;
            out_index   <= '0;
        end else if (clear) begin
            // History is wiped, but an index already in the output register is still delivered.
            pending     <= '0;
            seen        <= '0;
            ptr         <= '0;
            hit_count   <= '0;
            all_covered <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            pending     <= pending_next;
            seen        <= seen_next;
            all_covered <= &seen_next;
            if (load) begin
                out_valid <= 1'b1;
                out_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
                ptr       <= (sel_idx == LAST) ? '0 : sel_idx + PTR_W'(1);
                hit_count <= hit_count + HC_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cover_event_serializer.sv
// Directed self-checking bench for cover_event_serializer; a second instance
// with a non-zero COVER_INDEX shares all inputs to check the index offset.
module tb_cover_event_serializer;

    localparam int unsigned WIDTH = 65;
    localparam int unsigned IDX_W = 64;
    localparam int unsigned HC_W  = $clog2(WIDTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  valid;
    logic              clear;
    logic              out_ready;

    logic              out_valid;
    logic [IDX_W-1:0]  out_index;
    logic [HC_W-1:0]   hit_count;
    logic              all_covered;

    logic              off_valid;
    logic [IDX_W-1:0]  off_index;
    logic [HC_W-1:0]   off_hit_count;
    logic              off_all_covered;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cover_event_serializer #(.WIDTH(WIDTH), .COVER_INDEX(0), .IDX_W(IDX_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .hit_count   (hit_count),
        .all_covered (all_covered)
    );

    cover_event_serializer #(.WIDTH(WIDTH), .COVER_INDEX(8875), .IDX_W(IDX_W)) dut_off (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .clear       (clear),
        .out_valid   (off_valid),
        .out_ready   (out_ready),
        .out_index   (off_index),
        .hit_count   (off_hit_count),
        .all_covered (off_all_covered)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] bit_at(input int unsigned i);
        logic [WIDTH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_index",   out_index,        64'd0);
        check("rst_hit_count",   64'(hit_count),   64'd0);
        check("rst_all_covered", 64'(all_covered), 64'd0);
        reset = 1'b0;

        // Single hit, held high afterwards
        out_ready = 1'b1;
        valid     = bit_at(5);
        step();
        check("single_lat1_valid", 64'(out_valid), 64'd0);
        step();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_index", out_index,      64'd5);
        check("single_count", 64'(hit_count), 64'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            check("single_no_repeat", 64'(out_valid), 64'd0);
        end
        valid = '0;
        check("single_count_held", 64'(hit_count), 64'd1);

        // Round-robin order from ptr=0
        do_reset();
        valid = bit_at(3) | bit_at(64) | bit_at(0);
        step();
        valid = '0;
        step();
        check("rr_idx0", out_index, 64'd0);
        step();
        check("rr_idx3", out_index, 64'd3);
        step();
        check("rr_idx64", out_index, 64'd64);
        check("rr_valid64", 64'(out_valid), 64'd1);
        check("offset_idx64", off_index, 64'd8939);
        step();
        check("rr_idle", 64'(out_valid), 64'd0);
        valid = bit_at(2) | bit_at(1);
        step();
        valid = '0;
        step();
        check("rr_idx1", out_index, 64'd1);
        step();
        check("rr_idx2", out_index, 64'd2);
        step();
        check("rr_idle2", 64'(out_valid), 64'd0);
        check("rr_count", 64'(hit_count), 64'd5);

        // Backpressure: 7 held while 9 arrives
        out_ready = 1'b0;
        valid     = bit_at(7);
        step();
        valid = bit_at(9);
        step();
        valid = '0;
        check("bp_valid0", 64'(out_valid), 64'd1);
        check("bp_index0", out_index,      64'd7);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_stable_valid", 64'(out_valid), 64'd1);
            check("bp_stable_index", out_index,      64'd7);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_index", out_index,      64'd9);
        step();
        check("bp_idle", 64'(out_valid), 64'd0);
        check("bp_count", 64'(hit_count), 64'd7);

        // Clear while index 1 is waiting
        do_reset();
        out_ready = 1'b0;
        valid     = bit_at(1) | bit_at(2);
        step();
        valid = '0;
        step();
        check("clr_pre_index", out_index,      64'd1);
        check("clr_pre_count", 64'(hit_count), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_held_valid", 64'(out_valid), 64'd1);
        check("clr_held_index", out_index,      64'd1);
        check("clr_count",      64'(hit_count), 64'd0);
        out_ready = 1'b1;
        step();
        check("clr_accepted", 64'(out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("clr_no_idx2", 64'(out_valid), 64'd0);
        end
        check("clr_count_after", 64'(hit_count), 64'd0);
        valid = bit_at(1);
        step();
        valid = '0;
        step();
        check("clr_rehit_valid", 64'(out_valid), 64'd1);
        check("clr_rehit_index", out_index,      64'd1);
        check("clr_rehit_count", 64'(hit_count), 64'd1);
        step();

        // Reset mid-stream
        valid = bit_at(10) | bit_at(11) | bit_at(12);
        step();
        valid = '0;
        step();
        check("midrst_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(hit_count), 64'd0);
        step();
        check("midrst_lost", 64'(out_valid), 64'd0);

        // Full coverage
        valid = '1;
        step();
        valid = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                check("full_allcov_before", 64'(all_covered), 64'd0);
            end
            step();
            check("full_valid",     64'(out_valid), 64'd1);
            check("full_index",     out_index,      64'(i));
            check("full_off_index", off_index,      64'(8875 + i));
        end
        check("full_count",  64'(hit_count),   64'd65);
        check("full_allcov", 64'(all_covered), 64'd1);
        step();
        check("full_idle",        64'(out_valid),   64'd0);
        check("full_allcov_hold", 64'(all_covered), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("full_clear_allcov", 64'(all_covered), 64'd0);
        check("full_clear_count",  64'(hit_count),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
